// File: rtl/cordic_prerotate_pkg.sv
// Shared constants for the CORDIC input conditioning stage and the rotation core.
// Angles are signed Q8.12 degrees.
package cordic_prerotate_pkg;

  localparam int W        = 20;
  localparam int CORE_LAT = 10;

  localparam logic signed [W-1:0] DEG90 = 20'sh5A000;
  localparam logic signed [W-1:0] NEG90 = -DEG90;
  localparam logic signed [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    QUAD_NONE = 2'b00,
    QUAD_POS  = 2'b01,
    QUAD_NEG  = 2'b10
  } quad_e;

  // atan(2^-i) in Q8.12 degrees, one entry per core stage
  localparam logic signed [W-1:0] ATAN_TAB [0:W-1] = '{
    20'sd184320, 20'sd108810, 20'sd57492, 20'sd29184, 20'sd14649,
    20'sd7331,   20'sd3667,   20'sd1833,  20'sd917,   20'sd458,
    20'sd229,    20'sd115,    20'sd57,    20'sd29,    20'sd14,
    20'sd7,      20'sd4,      20'sd2,     20'sd1,     20'sd0
  };

endpackage

// File: rtl/cordic_prerotate_if.sv
// Sample bus between the upstream source, the pre-rotation stage and the core.
interface cordic_prerotate_if;
  import cordic_prerotate_pkg::*;

  logic                in_valid;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] angle_in;
  logic                sat_clr;
  logic signed [W-1:0] x_pre;
  logic signed [W-1:0] y_pre;
  logic signed [W-1:0] angle_pre;
  logic                pre_valid;
  logic                core_valid;
  logic [1:0]          quad;
  logic                sat_flag;

  modport master (
    output in_valid, x_in, y_in, angle_in, sat_clr,
    input  x_pre, y_pre, angle_pre, pre_valid, core_valid, quad, sat_flag
  );

  modport slave (
    input  in_valid, x_in, y_in, angle_in, sat_clr,
    output x_pre, y_pre, angle_pre, pre_valid, core_valid, quad, sat_flag
  );
endinterface

// File: rtl/cordic_prerotate_valid_delay.sv
// N-deep single-bit shift register with async reset; tracks sample validity
// alongside a fixed-latency datapath.
module valid_delay #(
  parameter int N = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q[0] <= d_i;
      for (int i = 1; i < N; i++) sh_q[i] <= sh_q[i-1];
    end
  end

  assign q_o = sh_q[N-1];
endmodule

// File: rtl/cordic_prerotate.sv
// Folds any Q8.12 angle into [-90, +90] degrees with an exact +/-90 rotation of
// (x, y) ahead of the CORDIC core, and delays validity to match the core output.
module cordic_prerotate
  import cordic_prerotate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cordic_prerotate_if.slave bus
);

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] a);
    logic signed [W:0] n;
    n = -{a[W-1], a};
    if (n[W] != n[W-1]) return SMAX;
    return n[W-1:0];
  endfunction

  function automatic logic neg_ovf(input logic signed [W-1:0] a);
    logic signed [W:0] n;
    n = -{a[W-1], a};
    return n[W] != n[W-1];
  endfunction

  quad_e               cls_d;
  logic signed [W-1:0] x_p1_q, y_p1_q, ang_p1_q;
  quad_e               cls_p1_q;
  logic                vld_p1_q;
  logic signed [W-1:0] x_p2_d, y_p2_d, ang_p2_d;
  logic signed [W-1:0] x_p2_q, y_p2_q, ang_p2_q;
  logic                vld_p2_q;
  quad_e               quad_d, quad_q;
  logic                ovf, sat_d, sat_q;

  always_comb begin
    cls_d = QUAD_NONE;
    if (bus.angle_in > DEG90)      cls_d = QUAD_POS;
    else if (bus.angle_in < NEG90) cls_d = QUAD_NEG;
  end

  // stage 1: capture sample and fold class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p1_q   <= '0;
      y_p1_q   <= '0;
      ang_p1_q <= '0;
      cls_p1_q <= QUAD_NONE;
      vld_p1_q <= 1'b0;
    end else begin
      x_p1_q   <= bus.x_in;
      y_p1_q   <= bus.y_in;
      ang_p1_q <= bus.angle_in;
      cls_p1_q <= cls_d;
      vld_p1_q <= bus.in_valid;
    end
  end

  always_comb begin
    x_p2_d   = x_p1_q;
    y_p2_d   = y_p1_q;
    ang_p2_d = ang_p1_q;
    ovf      = 1'b0;
    case (cls_p1_q)
      QUAD_POS: begin
        x_p2_d   = neg_sat(y_p1_q);
        y_p2_d   = x_p1_q;
        ang_p2_d = ang_p1_q - DEG90;
        ovf      = neg_ovf(y_p1_q);
      end
      QUAD_NEG: begin
        x_p2_d   = y_p1_q;
        y_p2_d   = neg_sat(x_p1_q);
        ang_p2_d = ang_p1_q + DEG90;
        ovf      = neg_ovf(x_p1_q);
      end
      default: ;
    endcase
    // invalid samples flow through but never touch quad or the sticky flag
    quad_d = vld_p1_q ? cls_p1_q : quad_q;
    if (vld_p1_q && ovf) sat_d = 1'b1;
    else if (bus.sat_clr) sat_d = 1'b0;
    else                  sat_d = sat_q;
  end

  // stage 2: rotated outputs to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p2_q   <= '0;
      y_p2_q   <= '0;
      ang_p2_q <= '0;
      vld_p2_q <= 1'b0;
      quad_q   <= QUAD_NONE;
      sat_q    <= 1'b0;
    end else begin
      x_p2_q   <= x_p2_d;
      y_p2_q   <= y_p2_d;
      ang_p2_q <= ang_p2_d;
      vld_p2_q <= vld_p1_q;
      quad_q   <= quad_d;
      sat_q    <= sat_d;
    end
  end

  valid_delay #(.N(CORE_LAT)) u_core_vld (
    .clk (clk),
    .rst (rst),
    .d_i (vld_p2_q),
    .q_o (bus.core_valid)
  );

  assign bus.x_pre     = x_p2_q;
  assign bus.y_pre     = y_p2_q;
  assign bus.angle_pre = ang_p2_q;
  assign bus.pre_valid = vld_p2_q;
  assign bus.quad      = quad_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed bench for cordic_prerotate with hand-computed expected values.
module tb_cordic_prerotate;
  import cordic_prerotate_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  cordic_prerotate_if bus ();

  cordic_prerotate dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [19:0] x, input logic [19:0] y,
                      input logic [19:0] a, input logic v);
    bus.x_in     = x;
    bus.y_in     = y;
    bus.angle_in = a;
    bus.in_valid = v;
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [19:0] x, input logic [19:0] y,
                         input logic [19:0] a, input logic [1:0] q);
    chk({tag, ".x"}, bus.x_pre, x);
    chk({tag, ".y"}, bus.y_pre, y);
    chk({tag, ".ang"}, bus.angle_pre, a);
    chk({tag, ".quad"}, {18'd0, bus.quad}, {18'd0, q});
    chk({tag, ".pv"}, {19'd0, bus.pre_valid}, 20'd1);
  endtask

  logic pat [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic expv;

  initial begin
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.angle_in = '0;
    bus.sat_clr  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst.pv", {19'd0, bus.pre_valid}, 20'd0);
    chk("rst.cv", {19'd0, bus.core_valid}, 20'd0);
    chk("rst.sat", {19'd0, bus.sat_flag}, 20'd0);
    chk("rst.x", bus.x_pre, 20'h0);
    chk("rst.y", bus.y_pre, 20'h0);
    chk("rst.ang", bus.angle_pre, 20'h0);
    chk("rst.quad", {18'd0, bus.quad}, 20'd0);

    send(20'h10000, 20'h00000, 20'h78000, 1'b1);
    chk_out("pos120", 20'h00000, 20'h10000, 20'h1E000, 2'b01);
    step();
    chk("idle.pv", {19'd0, bus.pre_valid}, 20'd0);
    chk("idle.quad", {18'd0, bus.quad}, 20'd1);

    send(20'h10000, 20'h00000, 20'h88000, 1'b1);
    chk_out("neg120", 20'h00000, 20'hF0000, 20'hE2000, 2'b10);

    send(20'h12345, 20'h0ABCD, 20'h5A000, 1'b1);
    chk_out("p90", 20'h12345, 20'h0ABCD, 20'h5A000, 2'b00);
    send(20'h12345, 20'h0ABCD, 20'hA6000, 1'b1);
    chk_out("m90", 20'h12345, 20'h0ABCD, 20'hA6000, 2'b00);
    send(20'h12345, 20'h0ABCD, 20'h5A001, 1'b1);
    chk_out("p90p", 20'hF5433, 20'h12345, 20'h00001, 2'b01);
    send(20'h12345, 20'h0ABCD, 20'hA5FFF, 1'b1);
    chk_out("m90m", 20'h0ABCD, 20'hEDCBB, 20'hFFFFF, 2'b10);

    send(20'h00000, 20'h80000, 20'h64000, 1'b0);
    chk("inv.pv", {19'd0, bus.pre_valid}, 20'd0);
    chk("inv.sat", {19'd0, bus.sat_flag}, 20'd0);
    chk("inv.quad", {18'd0, bus.quad}, 20'd2);

    send(20'h00000, 20'h80000, 20'h64000, 1'b1);
    chk_out("satpos", 20'h7FFFF, 20'h00000, 20'h0A000, 2'b01);
    chk("satpos.sat", {19'd0, bus.sat_flag}, 20'd1);

    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.sat_clr  = 1'b1;
    step();
    bus.sat_clr  = 1'b0;
    chk("setclr.sat", {19'd0, bus.sat_flag}, 20'd1);
    bus.sat_clr  = 1'b1;
    step();
    bus.sat_clr  = 1'b0;
    chk("clr.sat", {19'd0, bus.sat_flag}, 20'd0);

    send(20'h80000, 20'h00000, 20'h88000, 1'b1);
    chk_out("satneg", 20'h00000, 20'h7FFFF, 20'hE2000, 2'b10);
    chk("satneg.sat", {19'd0, bus.sat_flag}, 20'd1);
    bus.sat_clr = 1'b1;
    step();
    bus.sat_clr = 1'b0;
    chk("clr2.sat", {19'd0, bus.sat_flag}, 20'd0);

    repeat (14) step();
    for (int j = 0; j < CORE_LAT + 8; j++) begin
      bus.in_valid = (j < 4) ? pat[j] : 1'b0;
      step();
      expv = 1'b0;
      if (j >= CORE_LAT + 1 && j - 1 - CORE_LAT < 4) expv = pat[j-1-CORE_LAT];
      chk($sformatf("pat.cv%0d", j), {19'd0, bus.core_valid}, {19'd0, expv});
    end

    bus.in_valid = 1'b1;
    repeat (14) step();
    chk("burst.cv", {19'd0, bus.core_valid}, 20'd1);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst.cv", {19'd0, bus.core_valid}, 20'd0);
    chk("midrst.pv", {19'd0, bus.pre_valid}, 20'd0);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < CORE_LAT + 3; k++) begin
      step();
      chk($sformatf("flush.cv%0d", k), {19'd0, bus.core_valid}, 20'd0);
    end
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 2; k <= CORE_LAT + 2; k++) begin
      step();
      chk($sformatf("new.cv%0d", k), {19'd0, bus.core_valid},
          (k == CORE_LAT + 2) ? 20'd1 : 20'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cordic_prerotate.md
Name: cordic_prerotate

Overview:
- Input conditioning stage placed directly upstream of the 20-bit CORDIC rotation pipeline.
- The pipeline converges only for angles within about ±99.9°. This block folds any signed Q8.12 angle in [-128°, +128°) into [-90°, +90°] by applying an exact ±90° pre-rotation to (x, y).
- It also tracks sample validity through the downstream pipeline, so consumers know which core outputs are real.

Parameters:
- W, 20, data and angle word width (signed two's complement, Q8.12 for angle).
- CORE_LAT, 10, clock cycles from the core's inputs to the core's outputs; sets the length of the valid delay line.
- DEG90, 20'h5A000, +90° in Q8.12. -90° is derived as its two's complement, 20'hA6000.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  qualifies x_in/y_in/angle_in this cycle.
- x_in  in  W  signed x operand.
- y_in  in  W  signed y operand.
- angle_in  in  W  signed Q8.12 angle, degrees.
- sat_clr  in  1  synchronous clear of sat_flag.
- x_pre  out  W  pre-rotated x, feeds the core's x_in.
- y_pre  out  W  pre-rotated y, feeds the core's y_in.
- angle_pre  out  W  reduced angle, feeds the core's angle_in.
- pre_valid  out  1  qualifies x_pre/y_pre/angle_pre.
- core_valid  out  1  pre_valid delayed CORE_LAT cycles; aligned with the core's x_out/y_out.
- quad  out  2  fold applied to the current output: 00 none, 01 +90 removed, 10 -90 removed.
- sat_flag  out  1  sticky; set when a negation saturated.

Behaviour:
- Reset (async, rst=1): all registers, outputs and the delay line go to 0. The block resumes on the first clk edge after rst deasserts.
- Stage 1 (register): on every edge, capture x_in/y_in/angle_in/in_valid. Classify the angle with signed compares:
  - angle > DEG90 → POS.
  - angle < -DEG90 → NEG.
  - otherwise → NONE.
  - Exactly ±90° is NONE; no fold is applied.
- Stage 2 (compute, registered outputs):
  - POS: x_pre = -y, y_pre = x, angle_pre = angle - DEG90.
  - NEG: x_pre = y, y_pre = -x, angle_pre = angle + DEG90.
  - NONE: pass-through.
- Latency: 2 cycles from in_valid to pre_valid. Throughput is one sample per cycle. There is no backpressure because the core cannot stall.
- Angle arithmetic cannot overflow for in-range inputs. The result is always within [-90°, +90°], so no angle saturation logic is needed.
- Negation rules:
  - Negation uses W+1-bit arithmetic.
  - The most negative input, -2^(W-1) = 20'h80000, saturates to 2^(W-1)-1 = 20'h7FFFF.
  - A saturation sets sat_flag, but only when the stage-1 valid bit is 1.
- Invalid samples still propagate their data. Data fields are don't-care when valid=0, but quad and sat_flag must not change because of them.
- sat_flag:
  - Set has priority over sat_clr in the same cycle.
  - It otherwise holds until sat_clr=1 or reset.
- core_valid: a CORE_LAT-deep shift register fed by pre_valid.
  - It reflects exactly the pattern of pre_valid, including gaps.
  - It shifts every cycle.
  - Reset mid-stream flushes it; no stale valid may appear after reset.
- No state machine beyond the pipeline. The block is fully deterministic per sample, with no inter-sample dependency except sat_flag.

Decomposition:
- Shared package: W, the Q8.12 angle constants (DEG90, NEG90, and the full arctan table used by the core stages), the quad encoding localparams, and CORE_LAT.
- One natural sub-module: valid_delay, a parameterised N-deep single-bit shift register with async reset. It is reusable on the core output side.

Test Plan:
- Reset then idle: pre_valid, core_valid, sat_flag and all data outputs are 0.
- x=0x10000, y=0, angle=0x78000 (120°), in_valid=1 at cycle 0 → cycle 2: x_pre=0x00000, y_pre=0x10000, angle_pre=0x1E000 (30°), quad=01, pre_valid=1.
- Same x/y, angle=0x88000 (-120°) → x_pre=0x00000, y_pre=0xF0000, angle_pre=0xE2000 (-30°), quad=10.
- Boundary at angle=0x5A000 (+90°) and 0xA6000 (-90°) → pass-through unchanged, quad=00.
- x=0, y=0x80000, angle=0x64000 (100°) → x_pre=0x7FFFF, sat_flag=1.
  - Assert sat_clr and a second saturating sample in the same cycle → flag stays 1.
  - sat_clr alone → flag clears.
- Valid pattern 1,0,1,1 → core_valid reproduces 1,0,1,1 exactly CORE_LAT+2 cycles after input.
  - Assert rst mid-burst → core_valid is 0 immediately and stays 0 until new valid samples arrive.
